// File: rtl/bitpack_sched.sv
// bitpack_sched: round-robin scheduler in front of the 32-bit bit packer.
// Shares the packer's (ilength, idata) port between NUM_REQ code sources and
// sequences end-of-segment flush (byte-align with 1-bits, optional word pad).
// Optional feature macro: BITPACK_SCHED_FLUSH_WORD_EN (adds the PAD state so a
// flush leaves the stream on a 32-bit boundary).
module bitpack_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [6*NUM_REQ-1:0]  req_len,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  stall,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [5:0]            pk_ilength,
    output logic [31:0]           pk_idata,
    output logic [31:0]           bit_count,
    output logic                  len_err
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [4:0]       bitpos_reg;
    logic [5:0]       pk_len_reg;
    logic [31:0]      pk_data_reg;
    logic [31:0]      bit_count_reg;
    logic             len_err_reg;

    logic [5:0]       req_len_arr  [NUM_REQ];
    logic [31:0]      req_data_arr [NUM_REQ];

    // Unpack the flat request buses into per-requester arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_len_arr[gi]  = req_len[6*gi +: 6];
            assign req_data_arr[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    logic             arb_en;
    logic [5:0]       sel_len;
    logic             sel_over;
    logic [5:0]       sel_eff;
    logic [2:0]       align_nb;
    logic [4:0]       pad_np;

    // Round-robin search: first valid requester after the last granted one.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_reg) + k) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
    end

    // Grants only in RUN, unstalled, with no flush asking to start.
    assign arb_en    = !rst && (state_reg == ST_RUN) && !stall && !flush_req;
    assign req_ready = (arb_en && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Oversized codes are issued as a full word and flagged.
    assign sel_len  = req_len_arr[gnt_idx];
    assign sel_over = sel_len > 6'd32;
    assign sel_eff  = sel_over ? 6'd32 : sel_len;

    // Bits needed to reach the next byte / word boundary (negation mod 8 / 32).
    assign align_nb = 3'(~bitpos_reg[2:0] + 3'd1);
    assign pad_np   = 5'(~bitpos_reg + 5'd1);

    logic [5:0]  issue_len;
    logic [31:0] issue_data;
    logic        len_err_set;
    logic        done_c;

    // Next-state, issue selection and flush sequencing.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        issue_len   = 6'd0;
        issue_data  = 32'd0;
        len_err_set = 1'b0;
        done_c      = 1'b0;
        if (!stall) begin
            case (state_reg)
                ST_RUN: begin
                    if (flush_req) begin
                        state_next = ST_ALIGN;
                    end else if (gnt_found) begin
                        ptr_next    = gnt_idx;
                        issue_len   = sel_eff;
                        issue_data  = req_data_arr[gnt_idx];
                        len_err_set = sel_over;
                    end
                end
                ST_ALIGN: begin
                    issue_len = {3'd0, align_nb};
                    for (int i = 0; i < 8; i++) begin
                        issue_data[i] = (3'(i) < align_nb);
                    end
`ifdef BITPACK_SCHED_FLUSH_WORD_EN
                    state_next = ST_PAD;
`else
                    state_next = ST_DONE;
`endif
                end
                ST_PAD: begin
                    issue_len  = {1'b0, pad_np};
                    state_next = ST_DONE;
                end
                default: begin
                    done_c     = 1'b1;
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign flush_done = done_c && !rst;

    // Registered packer interface, stream position and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            ptr_reg       <= PTR_W'(NUM_REQ - 1);
            bitpos_reg    <= 5'd0;
            pk_len_reg    <= 6'd0;
            pk_data_reg   <= 32'd0;
            bit_count_reg <= 32'd0;
            len_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            bitpos_reg    <= bitpos_reg + issue_len[4:0];
            pk_len_reg    <= issue_len;
            pk_data_reg   <= issue_data;
            bit_count_reg <= bit_count_reg + {26'd0, issue_len};
            len_err_reg   <= len_err_reg | len_err_set;
        end
    end

    assign pk_ilength = pk_len_reg;
    assign pk_idata   = pk_data_reg;
    assign bit_count  = bit_count_reg;
    assign len_err    = len_err_reg;

endmodule

// File: doc/bitpack_sched.md
Name: bitpack_sched

Overview:
- Scheduler/arbiter in front of the 32-bit bit packer in the capture encoder path.
- Shares the packer's single (ilength, idata) input port between NUM_REQ code sources (header writer, Huffman coder, marker writer, ...) using round-robin arbitration.
- Sequences end-of-segment flush: byte-aligns the stream with 1-bits, then optionally pads to a 32-bit boundary so the packer emits the final word.
- Tracks the stream bit position itself; no feedback from the packer is required.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester code valid
- req_len  in  6*NUM_REQ  flat, requester i at [6*i+:6]; code length 0..32
- req_data  in  32*NUM_REQ  flat, requester i at [32*i+:32]; code right-aligned
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle
- stall  in  1  downstream near-full; blocks issue
- flush_req  in  1  level; request segment flush
- flush_done  out  1  one-cycle pulse; flush complete
- pk_ilength  out  6  to packer ilength, registered
- pk_idata  out  32  to packer idata, registered
- bit_count  out  32  total bits issued since reset, wraps
- len_err  out  1  sticky; a req_len > 32 was accepted

Behaviour:
- Reset: state=RUN, rr pointer=NUM_REQ-1, bitpos=0, pk_ilength=0, pk_idata=0, bit_count=0, len_err=0, flush_done=0, req_ready=0.
- Transfer = req_valid[i] & req_ready[i]. At most one per cycle.
- Latency: code accepted in cycle t appears on pk_ilength/pk_idata in cycle t+1.
- In every cycle with no transfer and no pad issue, pk_ilength=0 and pk_idata=0 on the next cycle.
- bitpos is 5 bits, mod 32. bitpos and bit_count both advance by the issued length, registered with pk_*.
- Length rule: req_len > 32 is issued as 32 and sets len_err. req_len = 0 is granted and issued as a no-op.
- Arbitration, RUN only, stall=0, flush not pending:
  - Grant the first valid requester searching from ptr+1, wrapping.
  - ptr <= granted index.
  - No valid requester: no grant, ptr unchanged.
- stall=1: req_ready=0 in every state and no pad issue; state, ptr and bitpos hold.
- FSM:
  - RUN: flush_req=1 and stall=0 -> ALIGN. No grants in that cycle; flush wins over pending requests.
  - ALIGN (stall=0):
    - nb = (8 - bitpos[2:0]) mod 8.
    - nb != 0: issue nb 1-bits (pk_idata low nb bits = 1, rest 0).
    - Next state: PAD if FLUSH_WORD_EN, else DONE.
  - PAD (stall=0):
    - np = (32 - ((bitpos + issued-in-ALIGN) mod 32)) mod 32; compute from the post-align position.
    - np != 0: issue np 0-bits (pk_idata=0, pk_ilength=np).
    - Next state: DONE.
  - DONE: flush_done=1 for exactly one cycle, no grants -> RUN.
- After DONE, a flush_req still high at RUN starts another flush; with bitpos already aligned it issues nothing.
- ALIGN and PAD always take one cycle each (stall aside), even when the issued length is 0.
- Reset mid-flush: immediate return to RUN; flush_done is not pulsed.

Optional Feature:
- Macro BITPACK_SCHED_FLUSH_WORD_EN.
- Defined: the PAD state exists; flush leaves bitpos=0 and the packer emits the final word.
- Undefined: ALIGN goes directly to DONE; only byte alignment is guaranteed.

Test Plan:
- Reset, then req0 len=5 data=0x1F for one cycle -> req_ready=0001; next cycle pk_ilength=5, pk_idata=0x1F; bit_count=5.
- req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one grant per cycle.
- Issue 13 bits, then flush_req, macro undefined -> ALIGN issues pk_ilength=3, pk_idata=0x7; flush_done pulses; bit_count=16.
- Same stimulus with macro defined -> ALIGN issues 3 bits, PAD issues pk_ilength=16, pk_idata=0; bit_count=32; bitpos=0.
- req1 len=40 -> pk_ilength=32; len_err=1 and stays 1 until reset.
- Hold stall=1 during ALIGN with req_valid asserted -> no grants, pk_ilength=0; state holds until stall=0. Then assert rst in PAD -> pk_ilength=0, bit_count=0, no flush_done.
